// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one write port, two registered read ports with
// same-cycle write bypass, per-entry valid bits, tri-state read drivers and a sequenced flush.
module regfile_2r1w #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re_a,
   input  logic              re_b,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   input  logic              oe_a,
   input  logic              oe_b,
   output wire  [WIDTH-1:0]  rdata_a,
   output wire  [WIDTH-1:0]  rdata_b,
   output logic              valid_a,
   output logic              valid_b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              wr_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_wr_drop;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [DEPTH-1:0]  r_vld;
   logic [WIDTH-1:0]  r_rdata_a, r_rdata_b;
   logic              r_valid_a, r_valid_b;
   logic              w_wr_ok;
   logic              w_byp_a, w_byp_b;

   assign w_wr_ok = we && !r_busy;
   assign w_byp_a = w_wr_ok && (raddr_a == waddr);
   assign w_byp_b = w_wr_ok && (raddr_b == waddr);

   // Flush FSM state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Flush FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (flush) begin
               w_state_nxt = SWEEP;
               w_idx_nxt   = '0;
               w_busy_nxt  = 1'b1;
            end
         end
         SWEEP: begin
            w_idx_nxt = r_idx + ADDR_W'(1);
            if (r_idx == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Storage: sweep clears one entry per edge, otherwise accept writes
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_vld <= '0;
      end else if (r_state == SWEEP) begin
         r_mem[r_idx] <= '0;
         r_vld[r_idx] <= 1'b0;
      end else if (w_wr_ok) begin
         r_mem[waddr] <= wdata;
         r_vld[waddr] <= 1'b1;
      end
   end

   // Read registers with write bypass; wr_drop pulse
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
         r_valid_a <= 1'b0;
         r_valid_b <= 1'b0;
         r_wr_drop <= 1'b0;
      end else begin
         r_wr_drop <= we && r_busy;
         if (re_a) begin
            r_rdata_a <= w_byp_a ? wdata : r_mem[raddr_a];
            r_valid_a <= w_byp_a ? 1'b1  : r_vld[raddr_a];
         end
         if (re_b) begin
            r_rdata_b <= w_byp_b ? wdata : r_mem[raddr_b];
            r_valid_b <= w_byp_b ? 1'b1  : r_vld[raddr_b];
         end
      end
   end

   assign rdata_a = oe_a ? r_rdata_a : {WIDTH{1'bz}};
   assign rdata_b = oe_b ? r_rdata_b : {WIDTH{1'bz}};
   assign valid_a = r_valid_a;
   assign valid_b = r_valid_b;
   assign busy    = r_busy;
   assign done    = r_done;
   assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: reset, read/write, bypass, flush, dropped writes, reset mid-flush.
module tb_regfile_2r1w;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 2;

   logic              clk = 1'b0;
   logic              clr;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic              re_a, re_b;
   logic [ADDR_W-1:0] raddr_a, raddr_b;
   logic              oe_a, oe_b;
   tri1  [WIDTH-1:0]  rdata_a;
   tri1  [WIDTH-1:0]  rdata_b;
   logic              valid_a, valid_b;
   logic              flush;
   logic              busy, done, wr_drop;

   int checks = 0;
   int errors = 0;

   regfile_2r1w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .oe_a(oe_a), .oe_b(oe_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .valid_a(valid_a), .valid_b(valid_b), .flush(flush),
      .busy(busy), .done(done), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      we = 1'b1; waddr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   task automatic read_both(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      re_a = 1'b1; raddr_a = a; re_b = 1'b1; raddr_b = b;
      step();
      re_a = 1'b0; re_b = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 4; i++) begin
         read_both(ADDR_W'(i), ADDR_W'(3 - i));
         chk({tag, "_rd_a"}, 32'(rdata_a), 32'h00);
         chk({tag, "_rd_b"}, 32'(rdata_b), 32'h00);
         chk({tag, "_vl_a"}, 32'(valid_a), 32'h0);
         chk({tag, "_vl_b"}, 32'(valid_b), 32'h0);
      end
   endtask

   initial begin
      clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re_a = 1'b0; re_b = 1'b0; raddr_a = '0; raddr_b = '0;
      oe_a = 1'b1; oe_b = 1'b1; flush = 1'b0;

      // Reset state
      #23;
      chk("rst_rdata_a", 32'(rdata_a), 32'h00);
      chk("rst_rdata_b", 32'(rdata_b), 32'h00);
      chk("rst_valid_a", 32'(valid_a), 32'h0);
      chk("rst_valid_b", 32'(valid_b), 32'h0);
      chk("rst_busy",    32'(busy),    32'h0);
      chk("rst_done",    32'(done),    32'h0);
      chk("rst_wr_drop", 32'(wr_drop), 32'h0);
      oe_a = 1'b0;
      #1;
      chk("oe_a_off_hiz", 32'(rdata_a), 32'hFF);
      chk("oe_a_off_b_driven", 32'(rdata_b), 32'h00);
      oe_a = 1'b1;
      #1;
      clr = 1'b1;
      check_all_zero("post_rst");

      // Write then read on both ports
      write(2'd1, 8'hA5);
      write(2'd2, 8'h3C);
      read_both(2'd1, 2'd2);
      chk("wr_rd_a", 32'(rdata_a), 32'hA5);
      chk("wr_rd_b", 32'(rdata_b), 32'h3C);
      chk("wr_vl_a", 32'(valid_a), 32'h1);
      chk("wr_vl_b", 32'(valid_b), 32'h1);
      oe_b = 1'b0;
      #1;
      chk("oe_b_off_hiz", 32'(rdata_b), 32'hFF);
      oe_b = 1'b1;

      // re low holds registers
      raddr_a = 2'd0; raddr_b = 2'd0;
      step();
      chk("hold_a", 32'(rdata_a), 32'hA5);
      chk("hold_b", 32'(rdata_b), 32'h3C);
      chk("hold_vl_a", 32'(valid_a), 32'h1);

      // Bypass on both ports of the same write
      write(2'd3, 8'h11);
      we = 1'b1; waddr = 2'd3; wdata = 8'h77;
      re_a = 1'b1; raddr_a = 2'd3; re_b = 1'b1; raddr_b = 2'd3;
      step();
      we = 1'b0; re_a = 1'b0; re_b = 1'b0;
      chk("byp_a", 32'(rdata_a), 32'h77);
      chk("byp_b", 32'(rdata_b), 32'h77);
      chk("byp_vl_a", 32'(valid_a), 32'h1);
      chk("byp_vl_b", 32'(valid_b), 32'h1);
      // Unwritten entry 0 still invalid; entry 3 now holds 0x77
      read_both(2'd0, 2'd3);
      chk("nobyp_vl_a0", 32'(valid_a), 32'h0);
      chk("after_byp_b3", 32'(rdata_b), 32'h77);

      // Flush: fill, then pulse flush
      write(2'd0, 8'h10);
      write(2'd1, 8'h21);
      write(2'd2, 8'h32);
      write(2'd3, 8'h43);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_busy_c1", 32'(busy), 32'h1);
      chk("fl_done_c1", 32'(done), 32'h0);
      // Read during sweep sees pre-edge storage: entry 3 not yet cleared
      re_a = 1'b1; raddr_a = 2'd3;
      step();
      re_a = 1'b0;
      chk("fl_rd_during", 32'(rdata_a), 32'h43);
      chk("fl_busy_c2", 32'(busy), 32'h1);
      step();
      chk("fl_busy_c3", 32'(busy), 32'h1);
      step();
      chk("fl_busy_c4", 32'(busy), 32'h1);
      chk("fl_done_c4", 32'(done), 32'h0);
      step();
      chk("fl_busy_end", 32'(busy), 32'h0);
      chk("fl_done_pulse", 32'(done), 32'h1);
      step();
      chk("fl_done_low", 32'(done), 32'h0);
      check_all_zero("post_flush");

      // Write during flush is dropped
      write(2'd0, 8'h55);
      flush = 1'b1;
      step();
      flush = 1'b0;
      we = 1'b1; waddr = 2'd0; wdata = 8'hFF;
      step();
      we = 1'b0;
      chk("drop_pulse", 32'(wr_drop), 32'h1);
      step();
      chk("drop_low", 32'(wr_drop), 32'h0);
      step();
      step();
      chk("drop_fl_done", 32'(done), 32'h1);
      read_both(2'd0, 2'd0);
      chk("drop_rd_a0", 32'(rdata_a), 32'h00);
      chk("drop_vl_a0", 32'(valid_a), 32'h0);

      // Reset mid-flush
      write(2'd3, 8'h99);
      write(2'd1, 8'h5A);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("rmf_busy_c1", 32'(busy), 32'h1);
      step();
      chk("rmf_busy_c2", 32'(busy), 32'h1);
      clr = 1'b0;
      #1;
      chk("rmf_busy_rst", 32'(busy), 32'h0);
      chk("rmf_done_rst", 32'(done), 32'h0);
      step();
      step();
      chk("rmf_done_in_rst", 32'(done), 32'h0);
      #2;
      clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rmf_no_done", 32'(done), 32'h0);
      end
      chk("rmf_busy_idle", 32'(busy), 32'h0);
      check_all_zero("post_rmf");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised successor to the 4×8 register file. It provides DEPTH words of WIDTH bits with one write port and two independent registered read ports. Writes can be forwarded to a read of the same address in the same cycle, and each entry carries a valid bit. A sequenced flush clears the array one entry per cycle. The block sits between the datapath ALU and the shared data bus, and each read port has its own tri-state output enable.

## Interface
- WIDTH, 8, data word width (≥1)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- re_a / re_b  in  1  read enable, port A / B
- raddr_a / raddr_b  in  ADDR_W  read address, port A / B
- oe_a / oe_b  in  1  tri-state output enable, port A / B
- rdata_a / rdata_b  out  WIDTH  read data; Hi-Z when the matching oe is 0
- valid_a / valid_b  out  1  valid bit of the entry last read on port A / B
- flush  in  1  start a sequenced clear of all entries
- busy  out  1  flush in progress
- done  out  1  one-cycle pulse when a flush completes
- wr_drop  out  1  one-cycle pulse: a write was discarded because busy was high

## Operation
- **Reset (clr = 0, asynchronous):**
  - All entries become 0 and all valid bits 0.
  - Internal rdata registers 0; valid_a, valid_b 0.
  - busy, done, wr_drop 0; FSM in IDLE; sweep index 0.
- **Write:**
  - we = 1 and busy = 0 at an edge: mem[waddr] ← wdata and vld[waddr] ← 1.
  - we = 1 and busy = 1: the write is discarded and wr_drop = 1 for the next cycle.
- **Read, per port, independent:**
  - re = 1 at an edge: the port's rdata register and valid register load mem[raddr] and vld[raddr].
  - re = 0: both registers hold their value.
- **Bypass:**
  - Applies when re = 1, we = 1, busy = 0 and raddr == waddr at the same edge.
  - The read register loads wdata and valid loads 1, i.e. the newly written value rather than the old one.
  - Both ports may bypass the same write at once.
- **Read during flush:** returns storage as it was before the edge. No bypass of the clear.
- **Output drivers:** rdata_x = oe_x ? internal register : all-Z. valid_x is always driven.
- **Flush FSM, states IDLE and SWEEP:**
  - IDLE, flush = 1 at an edge: go to SWEEP, idx ← 0, busy ← 1.
  - A write present at that same edge is still accepted; the sweep then clears it.
  - SWEEP, each edge: mem[idx] ← 0, vld[idx] ← 0, idx ← idx + 1.
  - On the edge where idx = DEPTH−1: go to IDLE, busy ← 0, done ← 1 for one cycle, idx ← 0.
  - flush while in SWEEP is ignored; it does not restart the sweep.
  - flush = 1 held high after completion starts a new sweep on the first IDLE edge. The flush cycle itself therefore counts as IDLE.
- **Widths:** idx is ADDR_W bits and wraps naturally. Addresses are always in range, so there is no out-of-range case.

## Timing
- Read latency: 1 cycle. Data appears after the edge that sampled re.
- Write to a later read of the same address: 0 extra cycles with bypass; otherwise visible at the next edge.
- Flush:
  - busy rises after the edge that sampled flush and stays high for exactly DEPTH cycles.
  - done pulses in the cycle immediately after busy falls.
  - Total flush = DEPTH + 1 edges from request to done.
- wr_drop and done are registered pulses, high for exactly one cycle.
- clr asserted mid-sweep: immediate return to IDLE with busy = 0 and done = 0. Entries are cleared by the reset itself.
- clr deassertion is assumed synchronised externally. The first active edge after release behaves as IDLE.

## Test plan
- **Reset:** with clr = 0, read all 4 entries → rdata 0x00 and valid 0. With oe_a = 0 → rdata_a is all-Z.
- **Write then read:**
  - Write 0xA5→1, 0x3C→2.
  - Next cycle: re_a with raddr_a = 1 and re_b with raddr_b = 2.
  - One cycle later: rdata_a = 0xA5, rdata_b = 0x3C, both valid = 1.
- **Bypass:** entry 3 holds 0x11. Write 0x77→3 with re_a and raddr_a = 3 on the same edge → rdata_a = 0x77 and valid_a = 1 the next cycle, not 0x11.
- **Flush:**
  - Fill all entries, then pulse flush.
  - busy is high for 4 cycles, then done pulses once.
  - Re-reading all entries returns 0x00 with valid 0.
- **Write during flush:** we = 1 with waddr = 0 and wdata = 0xFF while busy → wr_drop pulses once and entry 0 reads 0x00 after the flush.
- **Reset mid-flush:** drive clr low at the 2nd busy cycle → busy falls immediately, done never pulses, all entries read 0.
